// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between the fetch and data stages with alternating grants and a watchdog
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t     state_q;
    logic [7:0] wd_q;
    logic       busy, timeout, grant_i, grant_d;
    // Grant decisions and completion pulses; an ack always beats a watchdog expiry in the same cycle,
    // and the requester just served is never re-granted on its own ack edge
    always_comb begin
        busy      = state_q != IDLE;
        timeout   = busy && !mem_ack && wd_q == 8'(TIMEOUT - 1);
        grant_d   = dm_req && (state_q == IDLE || (state_q == BUSY_I && mem_ack));
        grant_i   = if_req && ((state_q == IDLE && !dm_req) || (state_q == BUSY_D && mem_ack));
        if_ready  = state_q == BUSY_I && (mem_ack || timeout);
        dm_ready  = state_q == BUSY_D && (mem_ack || timeout);
        if_rdata  = (state_q == BUSY_I && mem_ack) ? mem_rdata : '0;
        dm_rdata  = (state_q == BUSY_D && mem_ack) ? mem_rdata : '0;
        stall_if  = if_req && !if_ready;
        stall_mem = dm_req && !dm_ready;
    end
    // Transaction sequencer: registers the granted command, holds it while busy, runs the watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            wd_q      <= '0;
        end else if (grant_d) begin
            state_q   <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wd_q      <= '0;
        end else if (grant_i) begin
            state_q  <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            wd_q     <= '0;
        end else if (busy && (mem_ack || timeout)) begin
            state_q <= IDLE;
            mem_req <= 1'b0;
            err     <= err | timeout;
            wd_q    <= '0;
        end else if (busy) begin
            wd_q <= wd_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven and randomized checks of the IF/MEM memory arbiter
module tb_mem_port_arbiter;
    localparam int T = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic if_ready, dm_ready, stall_if, stall_mem, mem_req, mem_we, err;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        exp_we;
    } vec_t;
    vec_t tbl[6];

    int          cur, age;
    logic        m_err, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        rq[2], served[2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int k);
        cur    = k;
        age    = 0;
        m_we   = k == 1 ? dm_we : 1'b0;
        m_addr = k == 1 ? dm_addr : if_addr;
        if (k == 1) m_wdata = dm_wdata;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0,         32'h0000_0013, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         32'h1234_5678, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_2008, 32'hCAFE_F00D, 32'h0,         2, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 3, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 7, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         32'h5A5A_5A5A, 7, 1'b0};

        // reset then idle
        repeat (3) tick();
        chk("rst_mem_req", mem_req, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_mem_req2", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", {if_ready, dm_ready}, 0);
        chk("rst_stall", {stall_if, stall_mem}, 0);

        // single fetch, ack two cycles after mem_req
        if_req = 1'b1; if_addr = 32'h100;
        #1 chk("sf_stall_idle", stall_if, 1);
        tick();
        chk("sf_mem_req", mem_req, 1);
        chk("sf_mem_addr", mem_addr, 32'h100);
        chk("sf_mem_we", mem_we, 0);
        chk("sf_stall_busy", stall_if, 1);
        tick();
        chk("sf_no_ready", if_ready, 0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        chk("sf_ready", if_ready, 1);
        chk("sf_rdata", if_rdata, 32'h0050_0093);
        chk("sf_stall_done", stall_if, 0);
        chk("sf_dm_ready", dm_ready, 0);
        tick();
        mem_ack = 1'b0; if_req = 1'b0;
        #1;
        chk("sf_ready_pulse", if_ready, 0);
        chk("sf_idle", mem_req, 0);

        // simultaneous requests: data first, fetch chained with no idle bubble
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("sim_we", mem_we, 1);
        chk("sim_addr", mem_addr, 32'h2000);
        chk("sim_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sim_stalls", {stall_if, stall_mem}, 2'b11);
        mem_ack = 1'b1;
        #1;
        chk("sim_dm_ready", {if_ready, dm_ready}, 2'b01);
        chk("sim_stalls_ack", {stall_if, stall_mem}, 2'b10);
        tick();
        mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        chk("sim_chain_req", mem_req, 1);
        chk("sim_chain_addr", mem_addr, 32'h104);
        chk("sim_chain_we", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0073;
        #1;
        chk("sim_if_ready", {if_ready, dm_ready}, 2'b10);
        chk("sim_if_rdata", if_rdata, 32'h0000_0073);
        tick();
        mem_ack = 1'b0; if_req = 1'b0;
        #1 chk("sim_idle", mem_req, 0);

        // single transactions from a table
        for (int i = 0; i < 6; i++) begin
            dm_we = tbl[i].we;
            if (tbl[i].d) begin
                dm_req = 1'b1; dm_addr = tbl[i].addr; dm_wdata = tbl[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = tbl[i].addr;
            end
            tick();
            chk("tbl_addr", mem_addr, tbl[i].addr);
            chk("tbl_we", mem_we, tbl[i].exp_we);
            if (tbl[i].d && tbl[i].we) chk("tbl_wdata", mem_wdata, tbl[i].wdata);
            for (int j = 0; j < tbl[i].dly; j++) begin
                chk("tbl_wait", {if_ready, dm_ready}, 0);
                tick();
            end
            mem_ack = 1'b1; mem_rdata = tbl[i].rdata;
            #1;
            chk("tbl_ready", {if_ready, dm_ready}, tbl[i].d ? 2'b01 : 2'b10);
            if (!(tbl[i].d && tbl[i].we)) chk("tbl_rdata", tbl[i].d ? dm_rdata : if_rdata, tbl[i].rdata);
            tick();
            mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
            #1;
            chk("tbl_idle", mem_req, 0);
            chk("tbl_err", err, 0);
        end

        // alternation with both requests held
        dm_req = 1'b1; dm_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h400;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) if_req = 1'b0;
            chk("alt_addr", mem_addr, (k % 2 == 0) ? 32'h3000 : 32'h400);
            mem_ack = 1'b1; mem_rdata = 32'h10 + k;
            #1;
            chk("alt_ready", {if_ready, dm_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            mem_ack = 1'b0;
        end
        #1 chk("alt_idle", mem_req, 0);
        dm_req = 1'b0;

        // watchdog on a load that is never acknowledged
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3004; mem_rdata = 32'hFFFF_FFFF;
        tick();
        for (int c = 1; c <= T; c++) begin
            chk("wd_ready", dm_ready, c == T);
            if (c < T) tick();
        end
        chk("wd_rdata", dm_rdata, 0);
        chk("wd_err_pre", err, 0);
        tick();
        dm_req = 1'b0;
        #1;
        chk("wd_err", err, 1);
        chk("wd_idle", mem_req, 0);
        mem_ack = 1'b1;
        #1 chk("wd_late_ack", {if_ready, dm_ready}, 0);
        tick();
        mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h200;
        tick();
        chk("wd_fetch_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
        #1;
        chk("wd_fetch_ready", if_ready, 1);
        chk("wd_fetch_rdata", if_rdata, 32'h0000_0093);
        tick();
        mem_ack = 1'b0; if_req = 1'b0;
        #1 chk("wd_err_sticky", err, 1);

        // reset during a fetch
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        chk("rm_busy", mem_req, 1);
        #2 rst_n = 1'b0; if_req = 1'b0;
        #1;
        chk("rm_req_drop", mem_req, 0);
        chk("rm_addr", mem_addr, 0);
        chk("rm_err", err, 0);
        tick();
        rst_n = 1'b1; mem_ack = 1'b1;
        #1 chk("rm_stray_ack", {if_ready, dm_ready}, 0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rm_idle", mem_req, 0);
        chk("rm_ready", {if_ready, dm_ready}, 0);

        // randomized traffic against a reference model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cur = -1; age = 0; m_err = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        rq[0] = 1'b0; rq[1] = 1'b0; served[0] = 1'b0; served[1] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic fin, e_if, e_dm;
            for (int k = 0; k < 2; k++)
                if (!rq[k] || served[k]) rq[k] = 1'($urandom);
            if (!if_req || served[0]) if_addr = $urandom;
            if (!dm_req || served[1]) begin
                dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom);
            end
            if_req = rq[0]; dm_req = rq[1];
            mem_ack = cur >= 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            #1;
            fin  = cur >= 0 && (mem_ack || age == T - 1);
            e_if = fin && cur == 0;
            e_dm = fin && cur == 1;
            chk("rnd_ready", {if_ready, dm_ready}, {e_if, e_dm});
            chk("rnd_stall", {stall_if, stall_mem}, {if_req && !e_if, dm_req && !e_dm});
            chk("rnd_mem_req", mem_req, cur >= 0);
            chk("rnd_err", err, m_err);
            if (cur >= 0) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", mem_we, m_we);
            end
            if (cur == 1) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            if (e_if) chk("rnd_if_rdata", if_rdata, mem_ack ? mem_rdata : 32'h0);
            if (e_dm && !m_we) chk("rnd_dm_rdata", dm_rdata, mem_ack ? mem_rdata : 32'h0);
            served[0] = e_if; served[1] = e_dm;
            if (cur < 0) begin
                if (dm_req) grant(1);
                else if (if_req) grant(0);
            end else if (mem_ack) begin
                if (cur == 0 ? dm_req : if_req) grant(1 - cur);
                else cur = -1;
            end else if (age == T - 1) begin
                cur = -1; m_err = 1'b1;
            end else age++;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
